render_frame_sched: RTL and testbench
=====================================

Name: render_frame_sched

Overview:
- Schedules matrix/vertex updates into the render datapath so the on-screen wireframe never tears mid-frame.
- Two requesters offer a 256-bit vertex matrix plus a 4-bit matrix state over valid/ready handshakes: port 0 is the host interface, port 1 is the auto-rotate generator.
- Round-robin arbitration picks one requester; the accepted update is held in a shadow register.
- The shadow register is committed to the active outputs once per vertical blanking period. The active outputs drive the renderer's mtrxIn and matrixState inputs.

Parameters:
- V_ACTIVE, 480, first v_cnt value of vertical blanking; blanking is v_cnt >= V_ACTIVE.
- V_TOTAL, 525, number of lines per frame; v_cnt range is 0..V_TOTAL-1.

Ports:
- CLK  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-low reset.
- v_cnt  input  10  current VGA line, synchronous to CLK.
- req0_valid  input  1  host request valid.
- req0_mtrx  input  256  host matrix, same packing as renderer mtrxIn.
- req0_state  input  4  host matrix state.
- req0_ready  output  1  host accept.
- req1_valid  input  1  auto-rotate request valid.
- req1_mtrx  input  256  auto-rotate matrix.
- req1_state  input  4  auto-rotate matrix state.
- req1_ready  output  1  auto-rotate accept.
- mtrx_out  output  256  active matrix to renderer mtrxIn.
- state_out  output  4  active matrixState to renderer.
- commit  output  1  one-cycle pulse on the cycle mtrx_out/state_out update.
- last_src  output  1  source of the most recent commit (0 = host, 1 = auto).
- pending  output  1  shadow register holds an uncommitted update.
- frame_cnt  output  16  count of blanking entries.

Behaviour:
- Reset, applied when rst==0 at a CLK edge:
  - mtrx_out=0, state_out=0, commit=0, last_src=0, pending=0, frame_cnt=0.
  - Round-robin pointer favours port 0; FSM enters IDLE; v_cnt history register is set to 0.
  - Reset mid-operation discards the shadow contents and any pending update.
- Blanking: vblank = (v_cnt >= V_ACTIVE). vblank_rise = vblank && previous-cycle v_cnt < V_ACTIVE, using a registered v_cnt.
- frame_cnt increments by 1 on each vblank_rise and wraps from 0xFFFF to 0.
- FSM states:
  - IDLE: req0_ready = req1_ready = 1 only while there is no valid request, or for the granted port only.
    - Arbitration is combinational: if exactly one port is valid, grant it. If both are valid, grant the port the pointer favours, then flip the pointer to the other port.
    - On handshake (valid & ready of the granted port): on the next edge, shadow <= {mtrx, state}, record the source, pending=1, go to PENDING.
    - The ungranted port's ready stays 0; its valid/data must be held stable by the requester.
  - PENDING: both readys are 0.
    - If vblank and the commit_done flag is 0: go to COMMIT.
    - Otherwise stay. A request accepted during blanking commits in that same blanking period if no commit occurred yet in it.
  - COMMIT: exactly one cycle.
    - mtrx_out/state_out <= shadow, last_src <= recorded source, commit=1, pending=0, commit_done=1.
    - Next state is HOLD.
  - HOLD: both readys are 0. Stay while vblank; go to IDLE when v_cnt < V_ACTIVE.
- commit_done clears on the first cycle with v_cnt < V_ACTIVE. This guarantees at most one commit per blanking period.
- Latency: handshake edge t → pending=1 at t+1. The commit pulse occurs at the earliest edge at or after t+2 on which vblank holds and commit_done=0. Outputs are stable for the entire active region.
- Commit pulse and a vblank_rise on the same edge: both take effect (frame_cnt increments and outputs update).
- Requests arriving while not in IDLE wait; there is no dropping or overwriting.
- If v_cnt jumps out of range (>= V_TOTAL), it is treated as blanking.
- mtrx_out/state_out change only on a COMMIT cycle, never during v_cnt < V_ACTIVE.

Test Plan:
- Reset, single request: rst low 2 cycles, v_cnt=100, req0_valid=1 with mtrx=256'h1 and state=4'h3.
  → req0_ready=1 for 1 cycle; pending=1; no commit until v_cnt=480.
  → Then commit=1 for one cycle, mtrx_out=256'h1, state_out=3, last_src=0; frame_cnt=1.
- Fairness: req0 and req1 held valid continuously over 4 frames.
  → Grants alternate 0,1,0,1; exactly one commit per frame; last_src sequence 0,1,0,1.
- Request inside blanking: accept req1 at v_cnt=490 with no prior commit in that blanking.
  → Commit before v_cnt wraps to 0, last_src=1.
  → A second request at v_cnt=500 is stalled until v_cnt=0 and commits in the next blanking.
- Tearing check: randomized requests over 10 frames.
  → mtrx_out never changes while v_cnt<480; commit count is ≤ 1 per frame; no request is lost.
- Reset mid-PENDING: accept at v_cnt=200, assert rst low at v_cnt=300.
  → All outputs return to 0, pending=0, and no commit occurs at the next blanking.
- frame_cnt wrap: preload via 65536 blanking entries (or force).
  → frame_cnt goes from 0xFFFF to 0.

Source files
------------

// File: rtl/render_frame_sched.sv
// render_frame_sched: tear-free scheduling of matrix updates into the renderer.
// Two requesters (0 = host, 1 = auto-rotate) offer a 256-bit matrix plus a
// 4-bit matrix state. A round-robin arbiter accepts one update into a shadow
// register. The shadow is copied to the active outputs at most once per
// vertical blanking period, so the wireframe never changes mid-frame.
//
// Handshake semantics (both request ports):
//   A transfer happens on a rising CLK edge where reqN_valid && reqN_ready.
//   Once reqN_valid is raised, the requester keeps it and its data stable
//   until that transfer edge. reqN_ready depends combinationally on the
//   valids and the arbiter, never on the request data. Ready is only ever
//   high in IDLE: both readys are high while no port is valid, otherwise
//   only the granted port is ready.
module render_frame_sched #(
    parameter int V_ACTIVE = 480,
    parameter int V_TOTAL  = 525
) (
    input  logic         CLK,
    input  logic         rst,
    input  logic [9:0]   v_cnt,
    input  logic         req0_valid,
    input  logic [255:0] req0_mtrx,
    input  logic [3:0]   req0_state,
    output logic         req0_ready,
    input  logic         req1_valid,
    input  logic [255:0] req1_mtrx,
    input  logic [3:0]   req1_state,
    output logic         req1_ready,
    output logic [255:0] mtrx_out,
    output logic [3:0]   state_out,
    output logic         commit,
    output logic         last_src,
    output logic         pending,
    output logic [15:0]  frame_cnt,
    output logic [1:0]   fsm_state
);

    localparam logic [9:0] V_ACT = 10'(V_ACTIVE);
    localparam logic [9:0] V_TOT = 10'(V_TOTAL);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PENDING = 2'd1,
        S_COMMIT  = 2'd2,
        S_HOLD    = 2'd3
    } state_t;

    state_t         state;
    state_t         state_next;

    logic [9:0]     v_cnt_q;
    logic           vblank;
    logic           vblank_rise;

    logic           rr_ptr;       // 0: port 0 wins a tie, 1: port 1 wins
    logic           both_valid;
    logic           grant;        // port selected by the arbiter this cycle
    logic           accept;       // handshake on the granted port
    logic           go_commit;    // shadow moves to the active outputs
    logic           commit_done;  // a commit already happened this blanking

    logic [255:0]   shadow_mtrx;
    logic [3:0]     shadow_state;
    logic           shadow_src;

    assign fsm_state = state;

    // Blanking detection; lines past the end of the frame also count as blanking.
    always_comb begin
        vblank      = (v_cnt >= V_ACT) || (v_cnt >= V_TOT);
        vblank_rise = vblank && (v_cnt_q < V_ACT);
    end

    // Round-robin arbitration: a lone valid port wins, a tie goes to rr_ptr.
    always_comb begin
        both_valid = req0_valid && req1_valid;
        grant      = 1'b0;
        if (both_valid) begin
            grant = rr_ptr;
        end else if (req1_valid) begin
            grant = 1'b1;
        end
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_next = S_PENDING;
                end
            end
            S_PENDING: begin
                if (vblank && !commit_done) begin
                    state_next = S_COMMIT;
                end
            end
            S_COMMIT: begin
                state_next = S_HOLD;
            end
            S_HOLD: begin
                if (!vblank) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // FSM outputs: readys, handshake strobe, commit strobe and pulse.
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        accept     = 1'b0;
        go_commit  = 1'b0;
        commit     = 1'b0;
        case (state)
            S_IDLE: begin
                if (!req0_valid && !req1_valid) begin
                    req0_ready = 1'b1;
                    req1_ready = 1'b1;
                end else begin
                    req0_ready = !grant;
                    req1_ready = grant;
                end
                accept = (req0_valid && req0_ready) || (req1_valid && req1_ready);
            end
            S_PENDING: begin
                go_commit = vblank && !commit_done;
            end
            S_COMMIT: begin
                commit = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Line history and frame counter; frame_cnt wraps naturally at 16 bits.
    always_ff @(posedge CLK) begin
        if (!rst) begin
            v_cnt_q   <= 10'd0;
            frame_cnt <= 16'd0;
        end else begin
            v_cnt_q <= v_cnt;
            if (vblank_rise) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

    // One-commit-per-blanking guard, re-armed by the first active line.
    always_ff @(posedge CLK) begin
        if (!rst) begin
            commit_done <= 1'b0;
        end else if (!vblank) begin
            commit_done <= 1'b0;
        end else if (go_commit) begin
            commit_done <= 1'b1;
        end
    end

    // Shadow capture on handshake; the pointer only moves when a tie was broken.
    always_ff @(posedge CLK) begin
        if (!rst) begin
            shadow_mtrx  <= 256'd0;
            shadow_state <= 4'd0;
            shadow_src   <= 1'b0;
            rr_ptr       <= 1'b0;
        end else if (accept) begin
            shadow_mtrx  <= grant ? req1_mtrx  : req0_mtrx;
            shadow_state <= grant ? req1_state : req0_state;
            shadow_src   <= grant;
            if (both_valid) begin
                rr_ptr <= !grant;
            end
        end
    end

    // Active outputs change only on the commit edge, which is always in blanking.
    always_ff @(posedge CLK) begin
        if (!rst) begin
            mtrx_out  <= 256'd0;
            state_out <= 4'd0;
            last_src  <= 1'b0;
        end else if (go_commit) begin
            mtrx_out  <= shadow_mtrx;
            state_out <= shadow_state;
            last_src  <= shadow_src;
        end
    end

    // Pending flag: set by a capture, cleared by the commit that consumes it.
    always_ff @(posedge CLK) begin
        if (!rst) begin
            pending <= 1'b0;
        end else if (accept) begin
            pending <= 1'b1;
        end else if (go_commit) begin
            pending <= 1'b0;
        end
    end

endmodule

// File: tb/tb_render_frame_sched.sv
// tb_render_frame_sched: directed and randomized bench for render_frame_sched
// with a behavioural reference model and a commit scoreboard.
module tb_render_frame_sched;

    localparam int V_ACTIVE = 480;
    localparam int V_TOTAL  = 525;
    localparam int W        = 261;

    // ---------------- clock / reset / DUT ----------------
    logic         CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic         rst;
    logic [9:0]   v_cnt;
    logic         req0_valid;
    logic [255:0] req0_mtrx;
    logic [3:0]   req0_state;
    logic         req0_ready;
    logic         req1_valid;
    logic [255:0] req1_mtrx;
    logic [3:0]   req1_state;
    logic         req1_ready;
    logic [255:0] mtrx_out;
    logic [3:0]   state_out;
    logic         commit;
    logic         last_src;
    logic         pending;
    logic [15:0]  frame_cnt;
    logic [1:0]   fsm_state;

    render_frame_sched #(.V_ACTIVE(V_ACTIVE), .V_TOTAL(V_TOTAL)) dut (
        .CLK(CLK), .rst(rst), .v_cnt(v_cnt),
        .req0_valid(req0_valid), .req0_mtrx(req0_mtrx), .req0_state(req0_state), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_mtrx(req1_mtrx), .req1_state(req1_state), .req1_ready(req1_ready),
        .mtrx_out(mtrx_out), .state_out(state_out), .commit(commit), .last_src(last_src),
        .pending(pending), .frame_cnt(frame_cnt), .fsm_state(fsm_state)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // phase: 0 accepting, 1 waiting for blanking, 2 commit pulse, 3 waiting for active
    int           m_phase;
    bit           m_known = 0;
    logic [255:0] m_mtrx, m_sh_mtrx;
    logic [3:0]   m_state, m_sh_state;
    bit           m_sh_src, m_last_src, m_pending, m_commit, m_done, m_ptr;
    int           m_prev_v;
    logic [15:0]  m_frame;
    bit           m_rdy0, m_rdy1, m_grant, m_hs0, m_hs1;

    function automatic void model_ready();
        m_rdy0  = 0;
        m_rdy1  = 0;
        m_grant = (req0_valid && req1_valid) ? m_ptr : bit'(req1_valid);
        if (m_phase == 0) begin
            if (!req0_valid && !req1_valid) begin
                m_rdy0 = 1;
                m_rdy1 = 1;
            end else begin
                m_rdy0 = !m_grant;
                m_rdy1 = m_grant;
            end
        end
    endfunction

    function automatic void model_edge();
        bit vb;
        m_hs0 = 0;
        m_hs1 = 0;
        if (!rst) begin
            m_phase = 0; m_mtrx = '0; m_state = '0; m_sh_mtrx = '0; m_sh_state = '0;
            m_sh_src = 0; m_last_src = 0; m_pending = 0; m_commit = 0; m_done = 0;
            m_ptr = 0; m_prev_v = 0; m_frame = '0; m_known = 1;
            return;
        end
        model_ready();
        vb = (int'(v_cnt) >= V_ACTIVE);
        if (vb && m_prev_v < V_ACTIVE) m_frame = m_frame + 16'd1;
        m_prev_v = int'(v_cnt);
        m_commit = 0;
        case (m_phase)
            0: begin
                m_hs0 = !m_grant && req0_valid && m_rdy0;
                m_hs1 = m_grant && req1_valid && m_rdy1;
                if (m_hs0 || m_hs1) begin
                    m_sh_mtrx  = m_hs1 ? req1_mtrx : req0_mtrx;
                    m_sh_state = m_hs1 ? req1_state : req0_state;
                    m_sh_src   = m_hs1;
                    m_pending  = 1;
                    if (req0_valid && req1_valid) m_ptr = !m_grant;
                    m_phase = 1;
                end
            end
            1: begin
                if (vb && !m_done) begin
                    m_mtrx = m_sh_mtrx; m_state = m_sh_state; m_last_src = m_sh_src;
                    m_pending = 0; m_done = 1; m_commit = 1; m_phase = 2;
                end
            end
            2: m_phase = 3;
            default: if (!vb) m_phase = 0;
        endcase
        if (!vb) m_done = 0;
    endfunction

    // ---------------- scoreboard / observers ----------------
    logic [W-1:0] exp_q[$];
    logic [255:0] prev_mtrx = '0;
    bit           prev_svb = 0;
    int           blank_commits = 0;
    int           n_commits = 0;
    int           last_commit_line = -1;
    int           acc_line = 9999;
    bit           src_log[8];

    // ---------------- driver state ----------------
    int line_ctr;
    bit keep0 = 0, keep1 = 0, rand_mode = 0;

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    task automatic tick();
        int           sv;
        bit           svb;
        bit           sb_push;
        logic [W-1:0] sb_item;
        logic [W-1:0] item;
        @(negedge CLK);
        model_ready();
        if (m_known) begin
            check("req0_ready", req0_ready, m_rdy0);
            check("req1_ready", req1_ready, m_rdy1);
        end
        sb_push = 0;
        sb_item = '0;
        if (rst) begin
            if (req0_valid && req0_ready) begin
                sb_push = 1; sb_item = {1'b0, req0_state, req0_mtrx};
            end else if (req1_valid && req1_ready) begin
                sb_push = 1; sb_item = {1'b1, req1_state, req1_mtrx};
            end
        end
        sv = int'(v_cnt);
        @(posedge CLK);
        model_edge();
        if (!rst) exp_q.delete();
        else if (sb_push) begin
            exp_q.push_back(sb_item);
            acc_line = sv;
        end
        #1;
        if (m_known) begin
            check("mtrx_out", mtrx_out, m_mtrx);
            check("state_out", state_out, m_state);
            check("commit", commit, m_commit);
            check("last_src", last_src, m_last_src);
            check("pending", pending, m_pending);
            check("frame_cnt", frame_cnt, m_frame);
        end
        if (commit === 1'b1) begin
            if (n_commits < 8) src_log[n_commits] = last_src;
            n_commits++;
            blank_commits++;
            last_commit_line = sv;
            if (exp_q.size() == 0) check("sb_nonempty", 0, 1);
            else begin
                item = exp_q.pop_front();
                check("sb_commit", {last_src, state_out, mtrx_out}, item);
            end
        end
        check("tear", rst && (mtrx_out !== prev_mtrx) && (sv < V_ACTIVE), 0);
        prev_mtrx = mtrx_out;
        svb = (sv >= V_ACTIVE);
        if (prev_svb && !svb) begin
            check("one_per_blank", blank_commits <= 1, 1);
            blank_commits = 0;
        end
        prev_svb = svb;
    endtask

    task automatic update_requesters();
        if (m_hs0) begin
            if (keep0) begin req0_mtrx = rand256(); req0_state = 4'($urandom_range(0, 15)); end
            else req0_valid = 0;
        end
        if (m_hs1) begin
            if (keep1) begin req1_mtrx = rand256(); req1_state = 4'($urandom_range(0, 15)); end
            else req1_valid = 0;
        end
        if (rand_mode) begin
            if (!req0_valid && $urandom_range(0, 29) == 0) begin
                req0_valid = 1; req0_mtrx = rand256(); req0_state = 4'($urandom_range(0, 15));
            end
            if (!req1_valid && $urandom_range(0, 29) == 0) begin
                req1_valid = 1; req1_mtrx = rand256(); req1_state = 4'($urandom_range(0, 15));
            end
        end
    endtask

    task automatic set_line(input int x);
        line_ctr = x;
        v_cnt    = 10'(x);
    endtask

    task automatic run_lines(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            update_requesters();
            line_ctr = (line_ctr + 1) % V_TOTAL;
            v_cnt = 10'(line_ctr);
            if (rand_mode && line_ctr >= 500 && line_ctr <= 520 && $urandom_range(0, 39) == 0)
                v_cnt = 10'($urandom_range(V_TOTAL, 1023));
        end
    endtask

    task automatic run_until(input int target);
        run_lines((target - line_ctr + V_TOTAL) % V_TOTAL);
    endtask

    task automatic do_reset(input int n);
        rst = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            update_requesters();
        end
        rst = 1;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #3_000_000;
        n_errors++;
        $display("FAIL watchdog fsm_state=%0d", fsm_state);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        rst = 0;
        req0_valid = 0; req0_mtrx = '0; req0_state = '0;
        req1_valid = 0; req1_mtrx = '0; req1_state = '0;
        set_line(100);

        // single host request after reset
        req0_valid = 1; req0_mtrx = 256'h1; req0_state = 4'h3;
        do_reset(2);
        n_commits = 0;
        run_until(481);
        check("t1_commits", n_commits, 1);
        check("t1_line", last_commit_line, 480);
        check("t1_mtrx", mtrx_out, 256'h1);
        check("t1_state", state_out, 4'h3);
        check("t1_src", last_src, 0);
        check("t1_frame", frame_cnt, 16'd1);

        // fairness with both ports continuously valid
        req0_valid = 1; req0_mtrx = rand256(); req0_state = 4'h5;
        req1_valid = 1; req1_mtrx = rand256(); req1_state = 4'hA;
        keep0 = 1; keep1 = 1;
        set_line(0);
        do_reset(2);
        n_commits = 0;
        run_lines(4 * V_TOTAL);
        check("fair_commits", n_commits, 4);
        check("fair_src0", src_log[0], 0);
        check("fair_src1", src_log[1], 1);
        check("fair_src2", src_log[2], 0);
        check("fair_src3", src_log[3], 1);
        keep0 = 0; keep1 = 0;
        req0_valid = 0; req1_valid = 0;

        // request inside blanking, then a stalled one
        set_line(0);
        do_reset(2);
        n_commits = 0;
        run_until(490);
        req1_valid = 1; req1_mtrx = rand256(); req1_state = 4'h9;
        run_until(492);
        check("blank_commits", n_commits, 1);
        check("blank_line", last_commit_line, 491);
        check("blank_src", last_src, 1);
        run_until(500);
        req1_valid = 1; req1_mtrx = rand256(); req1_state = 4'h6;
        acc_line = 9999;
        run_until(481);
        check("stall_accept_active", acc_line < V_ACTIVE, 1);
        check("stall_line", last_commit_line, 480);
        check("stall_commits", n_commits, 2);
        check("stall_state", state_out, 4'h6);

        // randomized traffic over 10 frames, then drain
        set_line(0);
        do_reset(2);
        rand_mode = 1;
        run_lines(10 * V_TOTAL);
        rand_mode = 0;
        run_lines(2 * V_TOTAL);
        check("rand_drain_queue", exp_q.size(), 0);
        check("rand_drain_pending", pending, 0);

        // reset while an update is pending
        set_line(0);
        do_reset(2);
        run_until(200);
        req0_valid = 1; req0_mtrx = rand256(); req0_state = 4'hC;
        run_until(300);
        check("mid_pending_before", pending, 1);
        do_reset(2);
        n_commits = 0;
        run_until(491);
        check("mid_no_commit", n_commits, 0);
        check("mid_pending_after", pending, 0);
        check("mid_mtrx", mtrx_out, 256'h0);
        check("mid_state", state_out, 4'h0);

        // frame counter wrap from a preloaded value
        set_line(0);
        tick();
        update_requesters();
        force dut.frame_cnt = 16'hFFFD;
        #1;
        release dut.frame_cnt;
        m_frame = 16'hFFFD;
        for (int k = 0; k < 3; k++) begin
            set_line(480);
            tick();
            update_requesters();
            if (k == 1) check("wrap_ffff", frame_cnt, 16'hFFFF);
            if (k == 2) check("wrap_zero", frame_cnt, 16'h0000);
            set_line(0);
            tick();
            update_requesters();
        end

        check("final_queue", exp_q.size(), m_pending ? 1 : 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
